// File: rtl/led_sched_pkg.sv
// Shared definitions for the round-robin breathing-LED scheduler.
// Optional build macro: LED_ACTIVE_LOW_EN (inverts every led_out bit, off = 1).
package led_sched_pkg;

   // Scheduler states
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_RAMP_UP   = 2'd1;
   localparam logic [1:0] ST_RAMP_DOWN = 2'd2;
   localparam logic [1:0] ST_NEXT      = 2'd3;

   // Level that turns an LED off at the pin
`ifdef LED_ACTIVE_LOW_EN
   localparam logic LED_OFF = 1'b1;
`else
   localparam logic LED_OFF = 1'b0;
`endif

endpackage

// File: rtl/led_breath_sched_tick.sv
// breath_tick_gen: microsecond prescaler and PWM period counter shared by
// every LED. clear has priority over enable; counters hold when disabled.
module breath_tick_gen #(
   parameter int CNT_US_MAX = 49,
   parameter int PWM_MAX    = 999
) (
   input  logic                             sys_clk,
   input  logic                             sys_rst,
   input  logic                             clear,
   input  logic                             enable,
   output logic                             tick_us,
   output logic [$clog2(PWM_MAX+1)-1:0]     cnt_pwm,
   output logic                             period_end
);

   localparam int UW = $clog2(CNT_US_MAX + 1);
   localparam int PW = $clog2(PWM_MAX + 1);

   logic [UW-1:0] cnt_us;

   assign tick_us    = enable && (cnt_us == UW'(CNT_US_MAX));
   assign period_end = tick_us && (cnt_pwm == PW'(PWM_MAX));

   // Microsecond prescaler: 0..CNT_US_MAX while enabled
   always_ff @(posedge sys_clk) begin
      if (sys_rst || clear) begin
         cnt_us <= '0;
      end else if (enable) begin
         if (cnt_us == UW'(CNT_US_MAX)) cnt_us <= '0;
         else                           cnt_us <= cnt_us + UW'(1);
      end
   end

   // PWM period counter: advances once per microsecond tick, wraps at PWM_MAX
   always_ff @(posedge sys_clk) begin
      if (sys_rst || clear) begin
         cnt_pwm <= '0;
      end else if (tick_us) begin
         if (cnt_pwm == PW'(PWM_MAX)) cnt_pwm <= '0;
         else                         cnt_pwm <= cnt_pwm + PW'(1);
      end
   end

endmodule

// File: rtl/led_breath_sched.sv
// led_breath_sched: one breath engine time-multiplexed round-robin across the
// enabled LEDs. Each enabled LED gets a full fade up and fade down, then a
// one-cycle NEXT slot picks the following enabled LED.
// Optional build macro: LED_ACTIVE_LOW_EN (active-low LED drive).
//
// Handshake: start and stop are single-cycle pulses with no ready; start is
// taken only in IDLE with a non-zero en_mask, stop is taken in any state and
// wins over start in the same cycle.
module led_breath_sched
   import led_sched_pkg::*;
#(
   parameter int NUM_LED    = 4,
   parameter int CNT_US_MAX = 49,
   parameter int PWM_MAX    = 999
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst,
   input  logic                         start,
   input  logic                         stop,
   input  logic [NUM_LED-1:0]           en_mask,
   output logic [NUM_LED-1:0]           led_out,
   output logic                         busy,
   output logic [$clog2(NUM_LED)-1:0]   cur_led,
   output logic                         cycle_done,
   output logic [1:0]                   state_dbg
);

   localparam int IW = $clog2(NUM_LED);
   localparam int DW = $clog2(PWM_MAX + 1);

   logic [1:0]         state;
   logic [DW-1:0]      duty;
   logic [DW-1:0]      cnt_pwm;
   logic               tick_us;
   logic               period_end;
   logic               duty_step;
   logic               ramping;
   logic               eng_clear;
   logic               eng_en;
   logic               pwm_on;
   logic [NUM_LED-1:0] led_next;

   // Next enabled LED after cur, wrapping; cur itself is the last candidate.
   // Passing cur = NUM_LED-1 yields the lowest set bit.
   function automatic logic [IW-1:0] rr_pick(input logic [NUM_LED-1:0] mask,
                                             input logic [IW-1:0]      cur);
      logic          found;
      logic [IW-1:0] idx;
      rr_pick = cur;
      found   = 1'b0;
      for (int k = 1; k <= NUM_LED; k++) begin
         idx = IW'((int'(cur) + k) % NUM_LED);
         if (!found && mask[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   assign ramping   = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);
   assign eng_en    = ramping && !stop;
   assign eng_clear = stop || !ramping;
   assign pwm_on    = (cnt_pwm < duty);
   // period_end already implies tick_us; the AND keeps the step qualifier explicit
   assign duty_step = period_end && tick_us;

   breath_tick_gen #(
      .CNT_US_MAX (CNT_US_MAX),
      .PWM_MAX    (PWM_MAX)
   ) u_tick (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .clear      (eng_clear),
      .enable     (eng_en),
      .tick_us    (tick_us),
      .cnt_pwm    (cnt_pwm),
      .period_end (period_end)
   );

   // Scheduler FSM with duty ramp and round-robin LED selection
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state   <= ST_IDLE;
         duty    <= '0;
         cur_led <= '0;
      end else if (stop) begin
         state <= ST_IDLE;
         duty  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && (en_mask != '0)) begin
                  state   <= ST_RAMP_UP;
                  cur_led <= rr_pick(en_mask, IW'(NUM_LED - 1));
                  duty    <= '0;
               end
            end
            ST_RAMP_UP: begin
               if (duty_step) begin
                  if (duty == DW'(PWM_MAX)) state <= ST_RAMP_DOWN;
                  else                      duty  <= duty + DW'(1);
               end
            end
            ST_RAMP_DOWN: begin
               if (duty_step) begin
                  if (duty == '0) state <= ST_NEXT;
                  else            duty  <= duty - DW'(1);
               end
            end
            default: begin
               if (en_mask != '0) begin
                  state   <= ST_RAMP_UP;
                  cur_led <= rr_pick(en_mask, cur_led);
                  duty    <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Next LED drive: only the breathing LED follows the PWM, all others off
   always_comb begin
      led_next = {NUM_LED{LED_OFF}};
      if (ramping) led_next[cur_led] = pwm_on ^ LED_OFF;
   end

   // Registered LED pins; stop forces them off on the following cycle
   always_ff @(posedge sys_clk) begin
      if (sys_rst || stop) led_out <= {NUM_LED{LED_OFF}};
      else                 led_out <= led_next;
   end

   assign busy       = (state != ST_IDLE);
   assign cycle_done = (state == ST_NEXT);
   assign state_dbg  = state;

endmodule

// File: tb/tb_led_breath_sched.sv
// Directed bench for led_breath_sched with NUM_LED=4, CNT_US_MAX=4, PWM_MAX=9:
// 50-cycle PWM period, 1000-cycle breath, 1001-cycle slot.
module tb_led_breath_sched;

   localparam int NUM_LED = 4;
   localparam int SLOT    = 1001;
`ifdef LED_ACTIVE_LOW_EN
   localparam logic [3:0] OFF_V = 4'hF;
`else
   localparam logic [3:0] OFF_V = 4'h0;
`endif

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       start   = 1'b0;
   logic       stop    = 1'b0;
   logic [3:0] en_mask = 4'b0000;
   logic [3:0] led_out;
   logic       busy;
   logic [1:0] cur_led;
   logic       cycle_done;
   logic [1:0] state_dbg;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int other_bits_err = 0;

   logic [1:0] exp_q[$];
   logic [7:0] hi_q[$];

   led_breath_sched #(
      .NUM_LED    (NUM_LED),
      .CNT_US_MAX (4),
      .PWM_MAX    (9)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .start      (start),
      .stop       (stop),
      .en_mask    (en_mask),
      .led_out    (led_out),
      .busy       (busy),
      .cur_led    (cur_led),
      .cycle_done (cycle_done),
      .state_dbg  (state_dbg)
   );

   // clock / cycle counter
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // monitor: cycle_done scoreboard, slot spacing, unselected LED bits
   logic       last_valid = 1'b0;
   int         last_cyc   = 0;
   always @(negedge sys_clk) begin
      logic [3:0] on_v;
      logic [3:0] sel;
      logic [1:0] e;
      if (!sys_rst) begin
         on_v = led_out ^ OFF_V;
         sel  = 4'b0001 << cur_led;
         if ((on_v & ~sel) != 4'b0000) other_bits_err++;
         if (!busy) last_valid = 1'b0;
         if (cycle_done) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected cur_led=%0d expected no pulse", cur_led);
            end else begin
               e = exp_q.pop_front();
               if (cur_led !== e) begin
                  errors++;
                  $display("FAIL done_cur_led actual=%0d expected=%0d", cur_led, e);
               end
            end
            if (last_valid) begin
               checks++;
               if (cyc - last_cyc != SLOT) begin
                  errors++;
                  $display("FAIL done_spacing actual=%0d expected=%0d", cyc - last_cyc, SLOT);
               end
            end
            last_valid = 1'b1;
            last_cyc   = cyc;
         end
      end
   end

   initial begin
      int   hi;
      logic [7:0] exp_hi;

      // reset held 3 cycles
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk) sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("rst_led_out", led_out, OFF_V);
      chk("rst_busy", busy, 0);
      chk("rst_cur_led", cur_led, 0);
      chk("rst_cycle_done", cycle_done, 0);
      chk("rst_state", state_dbg, 0);

      // start with empty mask is ignored
      start = 1'b1;
      @(negedge sys_clk) start = 1'b0;
      @(negedge sys_clk);
      chk("start_empty_busy", busy, 0);

      // rotation over 0101, then mask change to 1000, then to 0000
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd3);
      for (int k = 0; k < 10; k++) hi_q.push_back(8'(k * 5));
      for (int k = 9; k >= 0; k--) hi_q.push_back(8'(k * 5));

      en_mask = 4'b0101;
      start   = 1'b1;
      @(negedge sys_clk) start = 1'b0;
      // high-time of LED 0 over each of the 20 PWM periods of its breath
      for (int k = 0; k < 20; k++) begin
         hi = 0;
         for (int j = 0; j < 50; j++) begin
            @(negedge sys_clk);
            if ((led_out[0] ^ OFF_V[0]) == 1'b1) hi++;
         end
         exp_hi = hi_q.pop_front();
         chk($sformatf("hi_time_p%0d", k), hi, exp_hi);
      end

      repeat (1500) @(negedge sys_clk);
      chk("mid_breath_busy", busy, 1);
      chk("mid_breath_led0", cur_led, 0);
      en_mask = 4'b1000;

      repeat (1000) @(negedge sys_clk);
      chk("after_change_led3", cur_led, 3);
      en_mask = 4'b0000;

      repeat (510) @(negedge sys_clk);
      chk("empty_mask_idle_busy", busy, 0);
      chk("empty_mask_idle_state", state_dbg, 0);
      chk("empty_mask_cur_led", cur_led, 3);

      // stop 300 cycles into a breath (duty 6, LED would be lit next)
      en_mask = 4'b0101;
      start   = 1'b1;
      @(negedge sys_clk) start = 1'b0;
      repeat (300) @(negedge sys_clk);
      chk("pre_stop_busy", busy, 1);
      stop = 1'b1;
      @(negedge sys_clk) stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_led_out", led_out, OFF_V);
      chk("stop_cycle_done", cycle_done, 0);

      // start and stop together: stop wins
      start = 1'b1;
      stop  = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      stop  = 1'b0;
      @(negedge sys_clk);
      chk("start_stop_busy", busy, 0);
      chk("start_stop_led_out", led_out, OFF_V);

      repeat (20) @(negedge sys_clk);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("unselected_bits_quiet", other_bits_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
